// File: rtl/ram_arbiter_pkg.sv
// Shared types for the data-RAM arbiter: bus widths, FSM state and master identifiers.
package ram_arbiter_pkg;

   localparam int ARB_WAIT_W = 4;
   localparam int MEM_W      = 32;
   localparam int MEM_ADDR_W = 32;

   typedef logic [MEM_W-1:0]      mem_bus_t;
   typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
   typedef logic [MEM_W/8-1:0]    mem_be_t;

   typedef enum logic {ARB_NORMAL, ARB_BOOST} arb_state_e;
   typedef enum logic {MST_M0, MST_M1} mst_id_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester's access channel into the RAM arbiter.
// Handshake: req/we/be/addr/wdata are held by the master until gnt is seen high in the same
// cycle; gnt is combinational. rvalid pulses exactly one cycle after a read grant and is the
// only qualifier for rdata.
interface ram_arbiter_if;
   import ram_arbiter_pkg::*;

   logic      req;
   logic      we;
   mem_be_t   be;
   mem_addr_t addr;
   mem_bus_t  wdata;
   logic      gnt;
   logic      rvalid;
   mem_bus_t  rdata;

   modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/ram_arbiter_arb_starve_ctr.sv
// Starvation guard for the low-priority requester M1: counts lost cycles and raises boost
// once M1 has lost MAX_WAIT consecutive cycles.
module arb_starve_ctr import ram_arbiter_pkg::*; #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m1_req,
   input  logic                  m1_gnt,
   output logic                  boost,
   output arb_state_e            state,
   output logic [ARB_WAIT_W-1:0] wait_cnt
);

   localparam logic [ARB_WAIT_W-1:0] WAIT_LIMIT = ARB_WAIT_W'(MAX_WAIT - 1);
   localparam logic [ARB_WAIT_W-1:0] WAIT_MAX   = '1;

   arb_state_e            state_nxt;
   logic [ARB_WAIT_W-1:0] wait_cnt_nxt;
   logic                  losing;

   assign losing = m1_req & ~m1_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ARB_NORMAL;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = '0;
      case (state)
         ARB_NORMAL: begin
            if (losing) begin
               // Last tolerated loss: hand over to BOOST, count restarts from zero.
               if (wait_cnt >= WAIT_LIMIT) begin
                  state_nxt = ARB_BOOST;
               end else if (wait_cnt != WAIT_MAX) begin
                  wait_cnt_nxt = wait_cnt + 1'b1;
               end else begin
                  wait_cnt_nxt = wait_cnt;
               end
            end
         end
         ARB_BOOST: begin
            if (m1_gnt || !m1_req) begin
               state_nxt = ARB_NORMAL;
            end
         end
         default: state_nxt = ARB_NORMAL;
      endcase
   end

   assign boost = (state == ARB_BOOST);

endmodule

// File: rtl/ram_arbiter.sv
// Shares the data-RAM controller between the load/store unit (M0) and the DMA/debug loader (M1):
// one grant per cycle, M0 priority with starvation boost for M1, 1-cycle read response steering.
module ram_arbiter import ram_arbiter_pkg::*; #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ram_arbiter_if.slave          m0,
   ram_arbiter_if.slave          m1,
   output mem_bus_t              mem_wdata_o,
   output mem_addr_t             mem_waddr_o,
   output mem_be_t               mem_we_o,
   output mem_addr_t             mem_raddr_o,
   input  mem_bus_t              mem_rdata_i,
   output arb_state_e            arb_state,
   output logic [ARB_WAIT_W-1:0] wait_cnt
);

   logic    gnt0;
   logic    gnt1;
   logic    boost;
   logic    rd_pend;
   logic    rd_grant;
   mst_id_e rsel;

   // Grants are suppressed while reset is asserted so nothing reaches the RAM.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         if (boost && m1.req) begin
            gnt1 = 1'b1;
         end else if (m0.req) begin
            gnt0 = 1'b1;
         end else if (m1.req) begin
            gnt1 = 1'b1;
         end
      end
   end

   arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .m1_req   (m1.req),
      .m1_gnt   (gnt1),
      .boost    (boost),
      .state    (arb_state),
      .wait_cnt (wait_cnt)
   );

   assign m0.gnt = gnt0;
   assign m1.gnt = gnt1;

   // Ungranted cycles present M0's address/data; only mem_we_o matters then and it stays zero.
   always_comb begin
      mem_waddr_o = m0.addr;
      mem_raddr_o = m0.addr;
      mem_wdata_o = m0.wdata;
      mem_we_o    = '0;
      if (gnt1) begin
         mem_waddr_o = m1.addr;
         mem_raddr_o = m1.addr;
         mem_wdata_o = m1.wdata;
         mem_we_o    = m1.we ? m1.be : '0;
      end else if (gnt0) begin
         mem_we_o    = m0.we ? m0.be : '0;
      end
   end

   assign rd_grant = (gnt0 & ~m0.we) | (gnt1 & ~m1.we);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend <= 1'b0;
         rsel    <= MST_M0;
      end else begin
         rd_pend <= rd_grant;
         if (rd_grant) begin
            rsel <= gnt1 ? MST_M1 : MST_M0;
         end
      end
   end

   assign m0.rvalid = rd_pend & (rsel == MST_M0);
   assign m1.rvalid = rd_pend & (rsel == MST_M1);
   assign m0.rdata  = mem_rdata_i;
   assign m1.rdata  = mem_rdata_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic against a lost-cycle
// priority model and a reference copy of the RAM contents.
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   localparam int unsigned MAX_WAIT = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  init_en;
   mem_bus_t              mem_wdata_o;
   mem_addr_t             mem_waddr_o;
   mem_be_t               mem_we_o;
   mem_addr_t             mem_raddr_o;
   mem_bus_t              mem_rdata_i;
   arb_state_e            arb_state;
   logic [ARB_WAIT_W-1:0] wait_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   mem_bus_t   ram     [256];
   mem_bus_t   ref_ram [256];
   logic [32:0] exp_q[$];

   ram_arbiter_if m0_if();
   ram_arbiter_if m1_if();

   ram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .m0          (m0_if),
      .m1          (m1_if),
      .mem_wdata_o (mem_wdata_o),
      .mem_waddr_o (mem_waddr_o),
      .mem_we_o    (mem_we_o),
      .mem_raddr_o (mem_raddr_o),
      .mem_rdata_i (mem_rdata_i),
      .arb_state   (arb_state),
      .wait_cnt    (wait_cnt)
   );

   // ---------------- clock / RAM controller stand-in ----------------
   always #5 clk = ~clk;

   function automatic mem_bus_t seed_word(input int i);
      return (32'h9E37_79B9 * (i + 1)) ^ 32'h5A5A_0F0F;
   endfunction

   always @(posedge clk) begin
      if (init_en) begin
         for (int i = 0; i < 256; i++) ram[i] <= seed_word(i);
      end else begin
         for (int b = 0; b < 4; b++)
            if (mem_we_o[b]) ram[mem_waddr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
      mem_rdata_i <= ram[mem_raddr_o[9:2]];
   end

   function automatic void ref_write(input mem_addr_t a, input mem_be_t be, input mem_bus_t d);
      for (int b = 0; b < 4; b++)
         if (be[b]) ref_ram[a[9:2]][8*b +: 8] = d[8*b +: 8];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input bit id, input logic req, input logic we, input mem_be_t be,
                        input mem_addr_t addr, input mem_bus_t wdata);
      if (id) begin
         m1_if.req = req; m1_if.we = we; m1_if.be = be; m1_if.addr = addr; m1_if.wdata = wdata;
      end else begin
         m0_if.req = req; m0_if.we = we; m0_if.be = be; m0_if.addr = addr; m0_if.wdata = wdata;
      end
   endtask

   task automatic idle(input int n);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive(1'b0, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
      drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      tests_run++; if (m0_if.gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_m0_gnt: got %b want 0", m0_if.gnt); end
      tests_run++; if (m1_if.gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_m1_gnt: got %b want 0", m1_if.gnt); end
      tests_run++; if (mem_we_o !== 4'h0) begin tests_failed++; $display("FAIL reset_mem_we: got %h want 0", mem_we_o); end
      tests_run++; if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid: got %b%b want 00", m0_if.rvalid, m1_if.rvalid); end
      tests_run++; if (arb_state !== ARB_NORMAL || wait_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_fsm: got state %0d cnt %0d want 0 0", arb_state, wait_cnt); end
      rst_n = 1'b1;
      #1;
      tests_run++; if (m0_if.gnt !== 1'b1 || m1_if.gnt !== 1'b0) begin tests_failed++; $display("FAIL release_gnt: got m0 %b m1 %b want 1 0", m0_if.gnt, m1_if.gnt); end
      tests_run++; if (mem_we_o !== 4'hF) begin tests_failed++; $display("FAIL release_mem_we: got %h want f", mem_we_o); end
      idle(2);
   endtask

   task automatic test_m0_write_read();
      drive(1'b0, 1'b1, 1'b1, 4'b0011, 32'h10, 32'hAABB_CCDD);
      @(negedge clk);
      tests_run++; if (m0_if.gnt !== 1'b1) begin tests_failed++; $display("FAIL m0_wr_gnt: got %b want 1", m0_if.gnt); end
      tests_run++; if (mem_we_o !== 4'b0011) begin tests_failed++; $display("FAIL m0_wr_be: got %b want 0011", mem_we_o); end
      tests_run++; if (mem_waddr_o !== 32'h10 || mem_wdata_o !== 32'hAABB_CCDD) begin tests_failed++; $display("FAIL m0_wr_bus: got %h/%h want 10/aabbccdd", mem_waddr_o, mem_wdata_o); end
      ref_write(32'h10, 4'b0011, 32'hAABB_CCDD);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      @(negedge clk);
      tests_run++; if (m0_if.gnt !== 1'b1 || mem_raddr_o !== 32'h10 || mem_we_o !== 4'h0) begin tests_failed++; $display("FAIL m0_rd_issue: got gnt %b raddr %h we %h want 1 10 0", m0_if.gnt, mem_raddr_o, mem_we_o); end
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      tests_run++; if (m0_if.rvalid !== 1'b1 || m1_if.rvalid !== 1'b0) begin tests_failed++; $display("FAIL m0_rd_rvalid: got %b%b want 10", m0_if.rvalid, m1_if.rvalid); end
      tests_run++; if (m0_if.rdata[15:0] !== 16'hCCDD) begin tests_failed++; $display("FAIL m0_rd_low: got %h want ccdd", m0_if.rdata[15:0]); end
      tests_run++; if (m0_if.rdata !== ref_ram[4]) begin tests_failed++; $display("FAIL m0_rd_word: got %h want %h", m0_if.rdata, ref_ram[4]); end
      @(posedge clk); #1;
      idle(1);
   endtask

   task automatic test_m1_write_read();
      drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h20, 32'h1234_5678);
      @(negedge clk);
      tests_run++; if (m1_if.gnt !== 1'b1 || m0_if.gnt !== 1'b0) begin tests_failed++; $display("FAIL m1_wr_gnt: got m0 %b m1 %b want 0 1", m0_if.gnt, m1_if.gnt); end
      tests_run++; if (mem_we_o !== 4'hF || mem_waddr_o !== 32'h20 || mem_wdata_o !== 32'h1234_5678) begin tests_failed++; $display("FAIL m1_wr_bus: got %h %h %h want f 20 12345678", mem_we_o, mem_waddr_o, mem_wdata_o); end
      ref_write(32'h20, 4'hF, 32'h1234_5678);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
      @(negedge clk);
      tests_run++; if (m1_if.gnt !== 1'b1 || mem_raddr_o !== 32'h20) begin tests_failed++; $display("FAIL m1_rd_issue: got gnt %b raddr %h want 1 20", m1_if.gnt, mem_raddr_o); end
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      tests_run++; if (m1_if.rvalid !== 1'b1 || m0_if.rvalid !== 1'b0) begin tests_failed++; $display("FAIL m1_rd_rvalid: got m0 %b m1 %b want 0 1", m0_if.rvalid, m1_if.rvalid); end
      tests_run++; if (m1_if.rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL m1_rd_data: got %h want 12345678", m1_if.rdata); end
      @(posedge clk); #1;
      idle(1);
   endtask

   task automatic test_starvation();
      int ph;
      drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h34, 32'h0);
      for (int k = 0; k < 15; k++) begin
         ph = k % 5;
         @(negedge clk);
         tests_run++; if (m0_if.gnt !== (ph != 4) || m1_if.gnt !== (ph == 4)) begin tests_failed++; $display("FAIL starve_gnt[%0d]: got m0 %b m1 %b want %b %b", k, m0_if.gnt, m1_if.gnt, ph != 4, ph == 4); end
         tests_run++; if (arb_state !== ((ph == 4) ? ARB_BOOST : ARB_NORMAL) || wait_cnt !== ((ph == 4) ? 4'd0 : 4'(ph))) begin tests_failed++; $display("FAIL starve_fsm[%0d]: got state %0d cnt %0d want %0d %0d", k, arb_state, wait_cnt, ph == 4, (ph == 4) ? 0 : ph); end
         @(posedge clk); #1;
      end
      idle(2);
   endtask

   task automatic test_alternating_reads();
      bit        ids [3];
      mem_addr_t tbl [3];
      logic      g_obs, g_oth, v_obs, v_oth;
      mem_bus_t  d_obs;
      ids = '{1'b0, 1'b1, 1'b0};
      tbl = '{32'h40, 32'h44, 32'h48};
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         if (i < 3) drive(ids[i], 1'b1, 1'b0, 4'hF, tbl[i], 32'h0);
         @(negedge clk);
         if (i < 3) begin
            g_obs = ids[i] ? m1_if.gnt : m0_if.gnt;
            g_oth = ids[i] ? m0_if.gnt : m1_if.gnt;
            tests_run++; if (g_obs !== 1'b1 || g_oth !== 1'b0) begin tests_failed++; $display("FAIL alt_gnt[%0d]: got own %b other %b want 1 0", i, g_obs, g_oth); end
         end
         if (i > 0) begin
            v_obs = ids[i-1] ? m1_if.rvalid : m0_if.rvalid;
            v_oth = ids[i-1] ? m0_if.rvalid : m1_if.rvalid;
            d_obs = ids[i-1] ? m1_if.rdata : m0_if.rdata;
            tests_run++; if (v_obs !== 1'b1 || v_oth !== 1'b0) begin tests_failed++; $display("FAIL alt_rvalid[%0d]: got own %b other %b want 1 0", i, v_obs, v_oth); end
            tests_run++; if (d_obs !== ref_ram[tbl[i-1][9:2]]) begin tests_failed++; $display("FAIL alt_rdata[%0d]: got %h want %h", i, d_obs, ref_ram[tbl[i-1][9:2]]); end
         end
         @(posedge clk); #1;
      end
      idle(1);
   endtask

   task automatic test_reset_mid_read();
      drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h50, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h54, 32'h0);
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      tests_run++; if (m0_if.gnt !== 1'b1 || wait_cnt !== 4'd2) begin tests_failed++; $display("FAIL rstmid_pre: got gnt %b cnt %0d want 1 2", m0_if.gnt, wait_cnt); end
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      tests_run++; if (m0_if.rvalid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_rvalid: got %b want 0", m0_if.rvalid); end
      tests_run++; if (wait_cnt !== 4'd0 || arb_state !== ARB_NORMAL) begin tests_failed++; $display("FAIL rstmid_fsm: got cnt %0d state %0d want 0 0", wait_cnt, arb_state); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++; if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_after: got %b%b want 00", m0_if.rvalid, m1_if.rvalid); end
      tests_run++; if (wait_cnt !== 4'd0 || arb_state !== ARB_NORMAL) begin tests_failed++; $display("FAIL rstmid_fsm_after: got cnt %0d state %0d want 0 0", wait_cnt, arb_state); end
      @(posedge clk); #1;
   endtask

   // Model: M1 wins if it has already lost MAX_WAIT consecutive cycles, or M0 is silent.
   task automatic test_random();
      int          lost = 0;
      bit          r0, r1, w0, w1, win0, win1;
      mem_be_t     b0, b1, exp_we;
      mem_addr_t   a0, a1, exp_a;
      mem_bus_t    d0, d1, exp_d, got_d;
      logic [32:0] e;
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         r0 = ($urandom_range(0, 99) < 70);
         r1 = ($urandom_range(0, 99) < 55);
         w0 = 1'($urandom_range(0, 1));
         w1 = 1'($urandom_range(0, 1));
         b0 = 4'($urandom_range(0, 15));
         b1 = 4'($urandom_range(0, 15));
         a0 = 32'h60 + 32'($urandom_range(0, 15)) * 4;
         a1 = 32'h60 + 32'($urandom_range(0, 15)) * 4;
         d0 = $urandom;
         d1 = $urandom;
         drive(1'b0, r0, w0, b0, a0, d0);
         drive(1'b1, r1, w1, b1, a1, d1);
         win1 = r1 && (lost >= int'(MAX_WAIT) || !r0);
         win0 = r0 && !win1;
         exp_we = (win0 && w0) ? b0 : (win1 && w1) ? b1 : 4'h0;
         exp_a  = win1 ? a1 : a0;
         exp_d  = win1 ? d1 : d0;
         @(negedge clk);
         tests_run++; if (m0_if.gnt !== win0 || m1_if.gnt !== win1) begin tests_failed++; $display("FAIL rnd_gnt[%0d]: got %b%b want %b%b", c, m0_if.gnt, m1_if.gnt, win0, win1); end
         tests_run++; if (mem_we_o !== exp_we) begin tests_failed++; $display("FAIL rnd_we[%0d]: got %h want %h", c, mem_we_o, exp_we); end
         if (win0 || win1) begin
            tests_run++; if (mem_waddr_o !== exp_a || mem_raddr_o !== exp_a || mem_wdata_o !== exp_d) begin tests_failed++; $display("FAIL rnd_bus[%0d]: got %h %h %h want %h %h", c, mem_waddr_o, mem_raddr_o, mem_wdata_o, exp_a, exp_d); end
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got_d = e[32] ? m1_if.rdata : m0_if.rdata;
            tests_run++; if (m0_if.rvalid !== !e[32] || m1_if.rvalid !== e[32] || got_d !== e[31:0]) begin tests_failed++; $display("FAIL rnd_resp[%0d]: got %b%b %h want m%0d %h", c, m0_if.rvalid, m1_if.rvalid, got_d, e[32], e[31:0]); end
         end else begin
            tests_run++; if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0) begin tests_failed++; $display("FAIL rnd_norsp[%0d]: got %b%b want 00", c, m0_if.rvalid, m1_if.rvalid); end
         end
         tests_run++; if (arb_state !== ((lost >= int'(MAX_WAIT)) ? ARB_BOOST : ARB_NORMAL) || wait_cnt !== ((lost >= int'(MAX_WAIT)) ? 4'd0 : 4'(lost))) begin tests_failed++; $display("FAIL rnd_fsm[%0d]: got state %0d cnt %0d lost %0d", c, arb_state, wait_cnt, lost); end
         if (win0 && !w0) exp_q.push_back({1'b0, ref_ram[a0[9:2]]});
         if (win1 && !w1) exp_q.push_back({1'b1, ref_ram[a1[9:2]]});
         if (win0 && w0) ref_write(a0, b0, d0);
         if (win1 && w1) ref_write(a1, b1, d1);
         lost = (r1 && !win1) ? lost + 1 : 0;
         @(posedge clk); #1;
      end
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         got_d = e[32] ? m1_if.rdata : m0_if.rdata;
         tests_run++; if (m0_if.rvalid !== !e[32] || m1_if.rvalid !== e[32] || got_d !== e[31:0]) begin tests_failed++; $display("FAIL rnd_drain: got %b%b %h want m%0d %h", m0_if.rvalid, m1_if.rvalid, got_d, e[32], e[31:0]); end
      end
      @(posedge clk); #1;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n   = 1'b0;
      init_en = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int i = 0; i < 256; i++) ref_ram[i] = seed_word(i);
      @(posedge clk); #1;
      init_en = 1'b0;
      test_reset();
      test_m0_write_read();
      test_m1_write_read();
      test_starvation();
      test_alternating_reads();
      test_reset_mid_read();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
